// File: rtl/alu_pkg.sv
// alu_seq shared types: FSM state, control bundle, default width.
// Multiply mode is built only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
    logic mul;
  } ctrl_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq operand/result handshake bundle.
// slave is the ALU side, master the CPU side.
interface alu_seq_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;

  modport slave (
    input  in_valid, x, y,
    input  zx, nx, zy, ny, f, no, mul,
    input  out_ready,
    output in_ready, out_valid,
    output out, zr, ng, cy
  );

  modport master (
    output in_valid, x, y,
    output zx, nx, zy, ny, f, no, mul,
    output out_ready,
    input  in_ready, out_valid,
    input  out, zr, ng, cy
  );
endinterface

// File: rtl/alu_datapath.sv
// Hack-style combinational ALU core with carry.
// fin_i bypasses the core so a multiply product reuses negation/flags.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  ctrl_t            ctrl_i,
  input  logic             fin_i,
  input  logic [WIDTH-1:0] fin_r_i,
  input  logic             fin_no_i,
  output logic [WIDTH-1:0] px_o,
  output logic [WIDTH-1:0] py_o,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             cy_o
);
  logic [WIDTH-1:0] zxv;
  logic [WIDTH-1:0] zyv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             neg;
  logic             unused_mul;

  assign unused_mul = ctrl_i.mul;

  always_comb begin
    zxv  = ctrl_i.zx ? '0 : x_i;
    zyv  = ctrl_i.zy ? '0 : y_i;
    px_o = ctrl_i.nx ? ~zxv : zxv;
    py_o = ctrl_i.ny ? ~zyv : zyv;
    sum  = {1'b0, px_o} + {1'b0, py_o};
    if (fin_i) begin
      r    = fin_r_i;
      neg  = fin_no_i;
      cy_o = 1'b0;
    end else begin
      r    = ctrl_i.f ? sum[WIDTH-1:0]
                      : (px_o & py_o);
      neg  = ctrl_i.no;
      cy_o = ctrl_i.f & sum[WIDTH];
    end
    out_o = neg ? ~r : r;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
  end
endmodule

// File: rtl/alu_seq.sv
// Registered Hack ALU with valid/ready handshake and carry flag.
// ALU_MUL_EN adds an iterative shift-add multiply (BUSY state).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  ctrl_t            ctrl;
  state_e           state_q;
  logic             ov_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q;
  logic             ng_q;
  logic             cy_q;

  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] py;
  logic [WIDTH-1:0] dp_out;
  logic             dp_zr;
  logic             dp_ng;
  logic             dp_cy;
  logic             fin;
  logic [WIDTH-1:0] fin_r;
  logic             fin_no;
  logic             is_mul;
  logic             rdy;
  logic             acc_en;
  logic             dlv;

  assign ctrl = '{zx: bus.zx, nx: bus.nx,
                  zy: bus.zy, ny: bus.ny,
                  f: bus.f, no: bus.no,
                  mul: bus.mul};

  assign rdy    = (state_q != BUSY) &&
                  (!ov_q || bus.out_ready);
  assign acc_en = bus.in_valid && rdy;
  assign dlv    = ov_q && bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cy        = cy_q;

`ifdef ALU_MUL_EN
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             no_q;

  assign acc_d  = acc_q +
                  (mplier_q[0] ? mcand_q : '0);
  assign is_mul = bus.mul;
  assign fin    = (state_q == BUSY);
  assign fin_r  = acc_d;
  assign fin_no = no_q;
`else
  logic unused_mul;
  assign unused_mul = ^{bus.mul, px, py};
  assign is_mul = 1'b0;
  assign fin    = 1'b0;
  assign fin_r  = '0;
  assign fin_no = 1'b0;
`endif

  alu_datapath #(.WIDTH(WIDTH)) u_dp (
    .x_i      (bus.x),
    .y_i      (bus.y),
    .ctrl_i   (ctrl),
    .fin_i    (fin),
    .fin_r_i  (fin_r),
    .fin_no_i (fin_no),
    .px_o     (px),
    .py_o     (py),
    .out_o    (dp_out),
    .zr_o     (dp_zr),
    .ng_o     (dp_ng),
    .cy_o     (dp_cy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ov_q     <= 1'b0;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      cy_q     <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      no_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_en && is_mul) begin
`ifdef ALU_MUL_EN
            mcand_q  <= px;
            mplier_q <= py;
            no_q     <= ctrl.no;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            state_q  <= BUSY;
`endif
            ov_q     <= 1'b0;
          end else if (acc_en) begin
            out_q <= dp_out;
            zr_q  <= dp_zr;
            ng_q  <= dp_ng;
            cy_q  <= dp_cy;
            ov_q  <= 1'b1;
          end else if (dlv) begin
            ov_q  <= 1'b0;
          end
        end
        BUSY: begin
`ifdef ALU_MUL_EN
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          // last iteration edge: product is acc_d
          if (cnt_q == CW'(1)) begin
            out_q   <= dp_out;
            zr_q    <= dp_zr;
            ng_q    <= dp_ng;
            cy_q    <= 1'b0;
            ov_q    <= 1'b1;
            state_q <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
// Multiply scenarios run only when ALU_MUL_EN is defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   c;
    logic [W-1:0] eo;
    logic [2:0]   fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[12];

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  function automatic vec_t mk(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [5:0]   c,
    input logic [W-1:0] eo,
    input logic [2:0]   fl
  );
    vec_t v;
    v.x = x; v.y = y; v.c = c;
    v.eo = eo; v.fl = fl;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic put(input vec_t v,
                     input logic m);
    bus.x  = v.x;
    bus.y  = v.y;
    {bus.zx, bus.nx, bus.zy,
     bus.ny, bus.f, bus.no} = v.c;
    bus.mul = m;
    bus.in_valid = 1'b1;
  endtask

  task automatic chk_res(input string t,
                         input vec_t v);
    chk({t, "_ov"},  32'(bus.out_valid), 1);
    chk({t, "_out"}, 32'(bus.out), 32'(v.eo));
    chk({t, "_zr"},  32'(bus.zr), 32'(v.fl[2]));
    chk({t, "_ng"},  32'(bus.ng), 32'(v.fl[1]));
    chk({t, "_cy"},  32'(bus.cy), 32'(v.fl[0]));
  endtask

  // accept edge counts as edge 1
  task automatic mul_op(input vec_t v,
                        output int edges,
                        output int low);
    edges = 0;
    low   = 0;
    @(negedge clk);
    put(v, 1'b1);
    #1;
    chk("mul_acc_rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!bus.in_ready) low++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (!bus.in_ready) low++;
      if (bus.out_valid) begin
        edges = n + 1;
        break;
      end
    end
  endtask

  initial begin
    int   rd;
    int   wr;
    int   edges;
    int   low;
    logic seen;
    logic [W-1:0] bexp[4];

    tbl[0]  = mk(5, 3, 6'b000010, 16'd8, 3'b000);
    tbl[1]  = mk(5, 3, 6'b010011, 16'h0002, 3'b000);
    tbl[2]  = mk(3, 5, 6'b010011, 16'hFFFE, 3'b011);
    tbl[3]  = mk(16'hFFFF, 1, 6'b000010, 0, 3'b101);
    tbl[4]  = mk(16'h1234, 16'h5678, 6'b111010,
                 16'hFFFF, 3'b010);
    tbl[5]  = mk(16'hF0F0, 16'h3C3C, 6'b000000,
                 16'h3030, 3'b000);
    tbl[6]  = mk(0, 0, 6'b000001, 16'hFFFF, 3'b010);
    tbl[7]  = mk(16'h1234, 16'h5678, 6'b101010,
                 0, 3'b100);
    tbl[8]  = mk(16'h8000, 16'h8000, 6'b000010,
                 0, 3'b101);
    tbl[9]  = mk(16'h1234, 0, 6'b000100,
                 16'h1234, 3'b000);
    tbl[10] = mk(16'h7FFF, 1, 6'b000010,
                 16'h8000, 3'b010);
    tbl[11] = mk(7, 16'h9999, 6'b011111,
                 16'h0008, 3'b001);
    bexp[0] = 16'd2; bexp[1] = 16'd4;
    bexp[2] = 16'd6; bexp[3] = 16'd8;

    bus.in_valid = 1'b0;
    bus.x = '0; bus.y = '0;
    {bus.zx, bus.nx, bus.zy, bus.ny} = 4'b0;
    {bus.f, bus.no, bus.mul} = 3'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 1);
    chk("rst_ov",  32'(bus.out_valid), 0);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_zr",  32'(bus.zr), 0);
    chk("rst_ng",  32'(bus.ng), 0);
    chk("rst_cy",  32'(bus.cy), 0);

    // back-to-back table, one per cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      put(tbl[i], 1'b0);
      #1;
      chk($sformatf("v%0d_rdy", i),
          32'(bus.in_ready), 1);
      if (i > 0)
        chk_res($sformatf("v%0d", i - 1), tbl[i - 1]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk_res("v11", tbl[11]);
    @(posedge clk);
    #1;
    chk("drain_ov", 32'(bus.out_valid), 0);
    chk("hold_out", 32'(bus.out), 32'(tbl[11].eo));

    // backpressure: four adds, consumer stalls 3 cycles
    rd = 0;
    wr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 4);
      if (wr < 4)
        put(mk(W'(wr + 1), W'(wr + 1), 6'b000010,
               0, 0), 1'b0);
      else
        bus.in_valid = 1'b0;
      #1;
      if (c >= 1 && c <= 3) begin
        chk($sformatf("bp%0d_rdy", c),
            32'(bus.in_ready), 0);
        chk($sformatf("bp%0d_ov", c),
            32'(bus.out_valid), 1);
        chk($sformatf("bp%0d_hold", c),
            32'(bus.out), 2);
      end
      if (bus.out_valid && bus.out_ready && rd < 4) begin
        chk($sformatf("bp_out%0d", rd),
            32'(bus.out), 32'(bexp[rd]));
        chk($sformatf("bp_cyc%0d", rd), c, 4 + rd);
        rd++;
      end
      if (bus.in_valid && bus.in_ready) wr++;
    end
    chk("bp_delivered", rd, 4);
    chk("bp_accepted", wr, 4);
    chk("bp_ov_end", 32'(bus.out_valid), 0);

`ifdef ALU_MUL_EN
    @(negedge clk);
    bus.out_ready = 1'b0;
    mul_op(mk(16'd300, 16'd300, 6'b000000, 0, 0),
           edges, low);
    chk("mul_edges", edges, W + 1);
    chk("mul_rdy_low", low, W + 1);
    chk_res("mul300",
            mk(0, 0, 0, 16'h5F90, 3'b000));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mul_dlv_ov", 32'(bus.out_valid), 0);

    mul_op(mk(16'd3, 16'd2, 6'b010000, 0, 0),
           edges, low);
    chk("muln_edges", edges, W + 1);
    chk_res("muln",
            mk(0, 0, 0, 16'hFFF8, 3'b010));

    mul_op(mk(16'd6, 16'd7, 6'b000001, 0, 0),
           edges, low);
    chk_res("mulno",
            mk(0, 0, 0, 16'hFFD5, 3'b010));

    @(negedge clk);
    put(mk(16'd300, 16'd300, 6'b000000, 0, 0), 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rdy", 32'(bus.in_ready), 1);
    chk("abort_ov", 32'(bus.out_valid), 0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 0);
`else
    @(negedge clk);
    put(mk(16'd2, 16'd3, 6'b000010, 0, 0), 1'b1);
    #1;
    chk("nomul_rdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk_res("nomul",
            mk(0, 0, 0, 16'd5, 3'b000));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
